// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer for the 5-stage RV32 core: load-use stall, branch flush,
// and data-memory freeze with timeout, plus saturating stall/flush counters.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_RUN      | normal issue; resolves load-use and branch hazards
// ST_MEM_WAIT | whole pipeline frozen until dmem_ready or timeout
module hazard_controller #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic [4:0]       rd_ID_EX,
    input  logic             mem_read_ID_EX,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [0:0]        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              timeout_nxt;
    logic              load_use, mem_stall, freeze, branch_acc, load_stall;

    always_comb begin
        load_use = mem_read_ID_EX && (rd_ID_EX != 5'd0) &&
                   ((use_rs1_ID && (rs1_ID == rd_ID_EX)) ||
                    (use_rs2_ID && (rs2_ID == rd_ID_EX)));
        mem_stall  = dmem_req && !dmem_ready;
        freeze     = (state == ST_MEM_WAIT) || mem_stall;
        // A taken branch squashes the ID instruction, so its load-use hazard is moot.
        branch_acc = !freeze && branch_taken;
        load_stall = !freeze && !branch_taken && load_use;
    end

    always_comb begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_freeze = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                pipe_freeze = 1'b1;
            end else if (branch_acc) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_stall) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        timeout_nxt  = 1'b0;
        case (state)
            ST_RUN: begin
                if (mem_stall) begin
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt >= WAIT_LAST) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                    timeout_nxt  = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= timeout_nxt;
            if (!pc_write && (stall_count != '1))
                stall_count <= stall_count + 1'b1;
            if (branch_acc && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed cases with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_hazard_controller;

    localparam int TO    = 8;
    localparam int SMALL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] rs1_ID, rs2_ID, rd_ID_EX;
    logic       use_rs1_ID, use_rs2_ID, mem_read_ID_EX, branch_taken, dmem_req, dmem_ready;

    logic              pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_freeze, mem_timeout;
    logic [31:0]       stall_count, flush_count;
    logic              pc_write_s, if_id_write_s, if_id_flush_s, id_ex_flush_s, pipe_freeze_s, mem_timeout_s;
    logic [SMALL-1:0]  stall_count_s, flush_count_s;

    hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .rd_ID_EX(rd_ID_EX),
        .mem_read_ID_EX(mem_read_ID_EX), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(SMALL)) dut_s (
        .clk(clk), .rst_n(rst_n), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .rd_ID_EX(rd_ID_EX),
        .mem_read_ID_EX(mem_read_ID_EX), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_write(pc_write_s), .if_id_write(if_id_write_s), .if_id_flush(if_id_flush_s),
        .id_ex_flush(id_ex_flush_s), .pipe_freeze(pipe_freeze_s), .mem_timeout(mem_timeout_s),
        .stall_count(stall_count_s), .flush_count(flush_count_s)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Model: a freeze episode is a run of frozen cycles; it ends when memory answers
    // or after TO frozen cycles, the latter raising a timeout flag for one cycle.
    bit     m_valid = 0;
    bit     m_in_wait = 0;
    int     m_episode = 0;
    bit     m_timeout = 0;
    longint m_stall = 0;
    longint m_flush = 0;

    always @(negedge clk) begin
        bit lu, fz, br, hz, pc;
        lu = mem_read_ID_EX && (rd_ID_EX != 0) &&
             ((use_rs1_ID && (rs1_ID == rd_ID_EX)) || (use_rs2_ID && (rs2_ID == rd_ID_EX)));
        if (!rst_n) begin
            fz = 0; br = 0; hz = 0;
        end else begin
            fz = m_in_wait || (dmem_req && !dmem_ready);
            br = !fz && branch_taken;
            hz = !fz && !branch_taken && lu;
        end
        pc = !(fz || hz);

        check("pc_write",    pc_write,    pc);
        check("if_id_write", if_id_write, pc);
        check("if_id_flush", if_id_flush, br);
        check("id_ex_flush", id_ex_flush, br || hz);
        check("pipe_freeze", pipe_freeze, fz);
        check("pc_write_s",    pc_write_s,    pc);
        check("pipe_freeze_s", pipe_freeze_s, fz);
        check("id_ex_flush_s", id_ex_flush_s, br || hz);
        if (m_valid) begin
            check("mem_timeout",   mem_timeout,   m_timeout);
            check("stall_count",   stall_count,   sat(m_stall, 32));
            check("flush_count",   flush_count,   sat(m_flush, 32));
            check("mem_timeout_s", mem_timeout_s, m_timeout);
            check("stall_count_s", stall_count_s, sat(m_stall, SMALL));
            check("flush_count_s", flush_count_s, sat(m_flush, SMALL));
        end

        if (!rst_n) begin
            m_valid = 1; m_in_wait = 0; m_episode = 0; m_timeout = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_timeout = 0;
            if (!pc) m_stall++;
            if (br)  m_flush++;
            if (fz) begin
                m_episode++;
                if (m_in_wait && dmem_ready) begin
                    m_in_wait = 0; m_episode = 0;
                end else if (m_episode == TO) begin
                    m_in_wait = 0; m_episode = 0; m_timeout = 1;
                end else begin
                    m_in_wait = 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rs1_ID = 0; rs2_ID = 0; rd_ID_EX = 0;
        use_rs1_ID = 0; use_rs2_ID = 0; mem_read_ID_EX = 0;
        branch_taken = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 0;
        set_idle();
        tick();
        rst_n = 1;
    endtask

    task automatic load_use_pair(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        mem_read_ID_EX = 1; rd_ID_EX = rd;
        rs1_ID = r1; rs2_ID = r2; use_rs1_ID = 1; use_rs2_ID = 1;
    endtask

    initial begin
        int nf, nt;
        rst_n = 0;
        set_idle();
        tick();
        do_reset();

        // lw x5 ; add x6,x5,x1
        load_use_pair(5'd5, 5'd5, 5'd1);
        @(negedge clk);
        check("t1_pc_write", pc_write, 0);
        check("t1_if_id_write", if_id_write, 0);
        check("t1_id_ex_flush", id_ex_flush, 1);
        tick(); set_idle();
        @(negedge clk);
        check("t1_stall_count", stall_count, 1);
        check("t1_pc_resume", pc_write, 1);

        // both operands match rd: still a single stall cycle
        tick(); load_use_pair(5'd9, 5'd9, 5'd9);
        @(negedge clk);
        check("t1b_pc_write", pc_write, 0);
        tick(); set_idle();
        @(negedge clk);
        check("t1b_stall_count", stall_count, 2);

        // x0 destination never stalls
        tick(); load_use_pair(5'd0, 5'd0, 5'd0);
        @(negedge clk);
        check("t2_pc_write", pc_write, 1);
        check("t2_id_ex_flush", id_ex_flush, 0);

        // branch wins over load-use
        tick(); load_use_pair(5'd7, 5'd7, 5'd2); branch_taken = 1;
        @(negedge clk);
        check("t3_if_id_flush", if_id_flush, 1);
        check("t3_id_ex_flush", id_ex_flush, 1);
        check("t3_pc_write", pc_write, 1);
        tick(); set_idle();
        @(negedge clk);
        check("t3_flush_count", flush_count, 1);
        check("t3_stall_count", stall_count, 2);

        // memory waits three cycles then answers
        do_reset();
        nf = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            dmem_req = (i < 4); dmem_ready = (i == 3);
            @(negedge clk);
            nf += int'(pipe_freeze);
        end
        check("t4_freeze_cycles", nf, 4);
        check("t4_stall_count", stall_count, 4);

        // memory never answers: timeout after TO frozen cycles
        do_reset();
        nf = 0; nt = 0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            dmem_req = (i < TO); dmem_ready = 0;
            @(negedge clk);
            nf += int'(pipe_freeze);
            nt += int'(mem_timeout);
            if (i == TO) check("t5_timeout_pulse", mem_timeout, 1);
        end
        check("t5_freeze_cycles", nf, TO);
        check("t5_timeout_count", nt, 1);

        // reset in the middle of a freeze
        do_reset();
        dmem_req = 1;
        for (int i = 0; i < 2; i++) tick();
        rst_n = 0;
        @(negedge clk);
        check("t6_freeze_in_reset", pipe_freeze, 0);
        check("t6_pc_in_reset", pc_write, 1);
        tick(); rst_n = 1; dmem_req = 0;
        @(negedge clk);
        check("t6_freeze_after", pipe_freeze, 0);
        check("t6_stall_count", stall_count, 0);
        nt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            nt += int'(mem_timeout);
        end
        check("t6_no_timeout", nt, 0);

        // saturation of the narrow counter
        do_reset();
        dmem_req = 1;
        for (int i = 0; i < 19; i++) tick();
        tick(); set_idle();
        @(negedge clk);
        check("sat_stall_wide", stall_count, 20);
        check("sat_stall_narrow", stall_count_s, 15);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tick();
            rst_n          = ($urandom_range(0, 199) != 0);
            rs1_ID         = 5'($urandom_range(0, 3));
            rs2_ID         = 5'($urandom_range(0, 3));
            rd_ID_EX       = 5'($urandom_range(0, 3));
            use_rs1_ID     = 1'($urandom_range(0, 1));
            use_rs2_ID     = 1'($urandom_range(0, 1));
            mem_read_ID_EX = ($urandom_range(0, 2) != 0);
            branch_taken   = ($urandom_range(0, 6) == 0);
            dmem_req       = ($urandom_range(0, 9) < 3);
            dmem_ready     = ($urandom_range(0, 9) < 2);
        end

        tick(); set_idle();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
